// File: rtl/cmp_sweep_ctrl.sv
// Exhaustive 4-bit comparator sweep: drives all 256 {A,B} pairs, scores cmp_out against MODE.
// Define CMP_SWEEP_FAILLOG_EN to build the first-mismatch capture register behind first_fail.
module cmp_sweep_ctrl #(
  parameter int HOLD = 4,
  parameter int MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cmp_out,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [8:0] pass_cnt,
  output logic [8:0] fail_cnt,
  output logic [8:0] first_fail
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // DRIVE occupies HOLD-1 cycles, so the hold counter tops out at HOLD-2.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 2);

  state_t     state_reg, state_next;
  logic [7:0] idx_reg, idx_next;
  logic [3:0] hold_reg, hold_next;
  logic [8:0] pass_reg, pass_next;
  logic [8:0] fail_reg, fail_next;
  logic       expected;
  logic       mismatch;
  logic       start_ok;
  logic       count_en;

  assign expected = (MODE == 1) ? (idx_reg[7:4] > idx_reg[3:0])
                                : (idx_reg[7:4] == idx_reg[3:0]);
  assign mismatch = (cmp_out != expected);
  assign start_ok = (state_reg == IDLE) && start && !abort;
  // A SAMPLE cut short by abort is discarded.
  assign count_en = (state_reg == SAMPLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      hold_reg  <= '0;
      pass_reg  <= '0;
      fail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      hold_reg  <= hold_next;
      pass_reg  <= pass_next;
      fail_reg  <= fail_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    hold_next  = hold_reg;
    pass_next  = pass_reg;
    fail_next  = fail_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          state_next = DRIVE;
          idx_next   = '0;
          hold_next  = '0;
          pass_next  = '0;
          fail_next  = '0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (hold_reg == HOLD_LAST) begin
          state_next = SAMPLE;
        end else begin
          hold_next = hold_reg + 4'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          if (mismatch) fail_next = fail_reg + 9'd1;
          else          pass_next = pass_reg + 9'd1;
          if (idx_reg == 8'hFF) begin
            state_next = DONE;
          end else begin
            state_next = DRIVE;
            idx_next   = idx_reg + 8'd1;
            hold_next  = '0;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign A        = idx_reg[7:4];
  assign B        = idx_reg[3:0];
  assign busy     = (state_reg == DRIVE) || (state_reg == SAMPLE);
  assign done     = (state_reg == DONE);
  assign pass_cnt = pass_reg;
  assign fail_cnt = fail_reg;

`ifdef CMP_SWEEP_FAILLOG_EN
  logic [8:0] first_fail_reg, first_fail_next;

  // Bit 8 doubles as the "already captured" flag so later mismatches are ignored.
  always_comb begin
    first_fail_next = first_fail_reg;
    if (start_ok) begin
      first_fail_next = '0;
    end else if (count_en && mismatch && !first_fail_reg[8]) begin
      first_fail_next = {1'b1, idx_reg};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) first_fail_reg <= '0;
    else        first_fail_reg <= first_fail_next;
  end

  assign first_fail = first_fail_reg;
`else
  assign first_fail = '0;
`endif

endmodule

// File: tb/tb_cmp_sweep_ctrl.sv
// Directed bench for cmp_sweep_ctrl: a MODE=0 and a MODE=1 instance swept side by side
// against behavioural comparator models with optional planted faults.
module tb_cmp_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       stuck0, fault1;
  logic       cmp0, cmp1;
  logic [3:0] a0, b0, a1, b1;
  logic       busy0, done0, busy1, done1;
  logic [8:0] pass0, fail0, ff0, pass1, fail1, ff1;

  int tests_run    = 0;
  int tests_failed = 0;

`ifdef CMP_SWEEP_FAILLOG_EN
  localparam logic [8:0] FF_STUCK = 9'h100;
  localparam logic [8:0] FF_BA    = 9'h1BA;
`else
  localparam logic [8:0] FF_STUCK = 9'h000;
  localparam logic [8:0] FF_BA    = 9'h000;
`endif

  always #5 clk = ~clk;

  assign cmp0 = stuck0 ? 1'b0 : (a0 == b0);
  assign cmp1 = (a1 > b1) ^ (fault1 && (a1 == 4'hB) && (b1 == 4'hA));

  cmp_sweep_ctrl #(.HOLD(4), .MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cmp_out(cmp0),
    .A(a0), .B(b0), .busy(busy0), .done(done0),
    .pass_cnt(pass0), .fail_cnt(fail0), .first_fail(ff0)
  );

  cmp_sweep_ctrl #(.HOLD(4), .MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cmp_out(cmp1),
    .A(a1), .B(b1), .busy(busy1), .done(done1),
    .pass_cnt(pass1), .fail_cnt(fail1), .first_fail(ff1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns at the falling edge where done is seen.
  task automatic sweep(input string tag);
    int cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_first"}, 32'(busy0), 32'd1);
    check({tag, "_ab_first"}, 32'({a0, b0}), 32'h00);
    check({tag, "_cnt_clear"}, 32'({pass0, fail0}), 32'h0);
    cyc = 1;
    while (!done0 && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_len"}, 32'(cyc), 32'd1025);
    check({tag, "_done1"}, 32'(done1), 32'd1);
    check({tag, "_busy_done"}, 32'(busy0), 32'd0);
    $display("[TB] sweep %s: cycles=%0d dut0 pass=%0d fail=%0d ff=%h | dut1 pass=%0d fail=%0d ff=%h",
             tag, cyc, pass0, fail0, ff0, pass1, fail1, ff1);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int dcount, d1, d2;
    logic gap_busy, next_busy, done_seen;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stuck0 = 1'b0; fault1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy_done", 32'({busy0, done0}), 32'd0);
    check("rst_ab", 32'({a0, b0}), 32'h00);
    check("rst_cnt", 32'({pass0, fail0, ff0}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal models on both instances
    sweep("ideal");
    check("ideal_pass0", 32'(pass0), 32'd256);
    check("ideal_fail0", 32'(fail0), 32'd0);
    check("ideal_ffvalid0", 32'(ff0[8]), 32'd0);
    check("ideal_pass1", 32'(pass1), 32'd256);
    @(negedge clk);
    check("after_done_low", 32'({done0, busy0}), 32'd0);
    check("idle_hold_ab", 32'({a0, b0}), 32'hFF);
    check("idle_hold_cnt", 32'(pass0), 32'd256);

    // MODE 0 against a comparator stuck at 0
    stuck0 = 1'b1;
    sweep("stuck0");
    check("stuck_fail0", 32'(fail0), 32'd16);
    check("stuck_pass0", 32'(pass0), 32'd240);
    check("stuck_ff0", 32'(ff0), 32'(FF_STUCK));
    stuck0 = 1'b0;
    @(negedge clk);

    // MODE 1 with a single faulty pair at A=B, B=A
    fault1 = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ff_clear_on_start", 32'(ff0), 32'd0);
    while (!done0) @(negedge clk);
    $display("[TB] sweep mode1_fault: dut1 pass=%0d fail=%0d ff=%h", pass1, fail1, ff1);
    check("mode1_fail1", 32'(fail1), 32'd1);
    check("mode1_pass1", 32'(pass1), 32'd255);
    check("mode1_ff1", 32'(ff1), 32'(FF_BA));
    fault1 = 1'b0;
    @(negedge clk);

    // Abort coincident with a SAMPLE (edge 40): that pair is not counted
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("[TB] abort@40: pass=%0d fail=%0d A=%h B=%h busy=%0d", pass0, fail0, a0, b0, busy0);
    check("abort40_busy", 32'(busy0), 32'd0);
    check("abort40_total", 32'(pass0 + fail0), 32'd9);
    check("abort40_ab", 32'({a0, b0}), 32'h09);
    check("abort40_total1", 32'(pass1 + fail1), 32'd9);
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      done_seen = done_seen | done0;
    end
    check("abort40_no_done", 32'(done_seen), 32'd0);

    // Abort in DRIVE (edge 42): pair 9 already counted
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (41) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("[TB] abort@42: pass=%0d fail=%0d A=%h B=%h", pass0, fail0, a0, b0);
    check("abort42_total", 32'(pass0 + fail0), 32'd10);
    check("abort42_ab", 32'({a0, b0}), 32'h0A);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy0), 32'd0);
    check("start_abort_cnt", 32'(pass0), 32'd10);
    @(negedge clk);

    // Asynchronous reset mid-sweep, then a clean restart
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_cnt", 32'({pass0, fail0}), 32'd0);
    check("midrst_ab", 32'({a0, b0}), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep("after_rst");
    check("after_rst_pass0", 32'(pass0), 32'd256);
    check("after_rst_fail0", 32'(fail0), 32'd0);
    @(negedge clk);

    // start held high: next sweep only after DONE, one done per sweep
    dcount = 0; d1 = 0; d2 = 0; gap_busy = 1'b1; next_busy = 1'b0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 2060; cyc++) begin
      @(negedge clk);
      if (done0) begin
        dcount++;
        if (dcount == 1) d1 = cyc;
        else if (dcount == 2) d2 = cyc;
      end
      if (cyc == 1026) gap_busy = busy0;
      if (cyc == 1027) next_busy = busy0;
    end
    start = 1'b0;
    $display("[TB] held start: done pulses=%0d at %0d,%0d", dcount, d1, d2);
    check("held_dcount", 32'(dcount), 32'd2);
    check("held_d1", 32'(d1), 32'd1025);
    check("held_d2", 32'(d2), 32'd2051);
    check("held_gap_idle", 32'(gap_busy), 32'd0);
    check("held_restart", 32'(next_busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("held_abort_idle", 32'(busy0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
